// File: rtl/esp_dma32_mem_responder_if.sv
// 32-bit ESP DMA bundle: read/write control requests plus read and write data channels.
// The master modport is the accelerator side; the slave modport is the memory responder.
interface esp_dma32_mem_responder_if;
  logic        dma_read_ctrl_valid;
  logic [31:0] dma_read_ctrl_data_index;
  logic [31:0] dma_read_ctrl_data_length;
  logic [2:0]  dma_read_ctrl_data_size;
  logic        dma_read_ctrl_ready;
  logic        dma_read_chnl_valid;
  logic [31:0] dma_read_chnl_data;
  logic        dma_read_chnl_ready;
  logic        dma_write_ctrl_valid;
  logic [31:0] dma_write_ctrl_data_index;
  logic [31:0] dma_write_ctrl_data_length;
  logic [2:0]  dma_write_ctrl_data_size;
  logic        dma_write_ctrl_ready;
  logic        dma_write_chnl_valid;
  logic [31:0] dma_write_chnl_data;
  logic        dma_write_chnl_ready;

  modport master (
    output dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
           dma_read_ctrl_data_size, dma_read_chnl_ready,
           dma_write_ctrl_valid, dma_write_ctrl_data_index, dma_write_ctrl_data_length,
           dma_write_ctrl_data_size, dma_write_chnl_valid, dma_write_chnl_data,
    input  dma_read_ctrl_ready, dma_read_chnl_valid, dma_read_chnl_data,
           dma_write_ctrl_ready, dma_write_chnl_ready
  );

  modport slave (
    input  dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
           dma_read_ctrl_data_size, dma_read_chnl_ready,
           dma_write_ctrl_valid, dma_write_ctrl_data_index, dma_write_ctrl_data_length,
           dma_write_ctrl_data_size, dma_write_chnl_valid, dma_write_chnl_data,
    output dma_read_ctrl_ready, dma_read_chnl_valid, dma_read_chnl_data,
           dma_write_ctrl_ready, dma_write_chnl_ready
  );
endinterface

// File: rtl/esp_dma32_mem_responder.sv
// Memory-side ESP DMA responder with host backdoor; first read beat one cycle after ctrl accept.
// Read beats hold under chnl_ready=0; write beats accepted only while a write burst has beats left.
module esp_dma32_mem_responder #(
  parameter int ADDR_W = 10
) (
  input  logic                clk,
  input  logic                rst,
  esp_dma32_mem_responder_if.slave dma,
  input  logic                host_we,
  input  logic [ADDR_W-1:0]   host_addr,
  input  logic [31:0]         host_wdata,
  output logic [31:0]         host_rdata,
  output logic                busy,
  output logic                err_size
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t state_q, state_d;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] ptr_q;
  logic [31:0]       remaining_q;
  logic              rd_vld_q;
  logic [31:0]       rd_dat_q;
  logic [31:0]       host_rdata_q;
  logic              err_size_q;

  logic              rd_ctrl_rdy, wr_ctrl_rdy, wr_chnl_rdy, rd_vld;
  logic              rd_req_hs, wr_req_hs, rd_beat_hs, wr_beat_hs;
  logic              in_burst, host_wr_ok;
  logic [ADDR_W-1:0] rd_base, wr_base;

  // Every output is forced low while rst is high, not just after the reset edge.
  assign rd_ctrl_rdy = (state_q == IDLE) && !rst;
  assign wr_ctrl_rdy = rd_ctrl_rdy && !dma.dma_read_ctrl_valid;
  assign wr_chnl_rdy = (state_q == WR) && (remaining_q != 32'd0) && !rst;
  assign rd_vld      = rd_vld_q && !rst;

  assign rd_req_hs  = dma.dma_read_ctrl_valid && rd_ctrl_rdy;
  assign wr_req_hs  = dma.dma_write_ctrl_valid && wr_ctrl_rdy;
  assign rd_beat_hs = rd_vld && dma.dma_read_chnl_ready;
  assign wr_beat_hs = dma.dma_write_chnl_valid && wr_chnl_rdy;

  assign rd_base    = dma.dma_read_ctrl_data_index[ADDR_W-1:0];
  assign wr_base    = dma.dma_write_ctrl_data_index[ADDR_W-1:0];
  assign in_burst   = (state_q != IDLE);
  assign host_wr_ok = host_we && !in_burst && !wr_beat_hs;

  assign dma.dma_read_ctrl_ready  = rd_ctrl_rdy;
  assign dma.dma_write_ctrl_ready = wr_ctrl_rdy;
  assign dma.dma_read_chnl_valid  = rd_vld;
  assign dma.dma_read_chnl_data   = rst ? 32'd0 : rd_dat_q;
  assign dma.dma_write_chnl_ready = wr_chnl_rdy;
  assign host_rdata               = rst ? 32'd0 : host_rdata_q;
  assign busy                     = in_burst && !rst;
  assign err_size                 = err_size_q && !rst;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (rd_req_hs && dma.dma_read_ctrl_data_length != 32'd0)
          state_d = RD;
        else if (wr_req_hs && dma.dma_write_ctrl_data_length != 32'd0)
          state_d = WR;
      end
      RD: if (rd_beat_hs && remaining_q == 32'd1) state_d = IDLE;
      WR: if (wr_beat_hs && remaining_q == 32'd1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ptr_q always points at the next word to fetch (read) or store (write).
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q        <= '0;
      remaining_q  <= 32'd0;
      rd_vld_q     <= 1'b0;
      rd_dat_q     <= 32'd0;
      host_rdata_q <= 32'd0;
      err_size_q   <= 1'b0;
    end else begin
      host_rdata_q <= mem[host_addr];
      if (rd_req_hs) begin
        ptr_q       <= rd_base + 1'b1;
        remaining_q <= dma.dma_read_ctrl_data_length;
        rd_vld_q    <= (dma.dma_read_ctrl_data_length != 32'd0);
        rd_dat_q    <= mem[rd_base];
        if (dma.dma_read_ctrl_data_size != 3'b010) err_size_q <= 1'b1;
      end else if (wr_req_hs) begin
        ptr_q       <= wr_base;
        remaining_q <= dma.dma_write_ctrl_data_length;
        if (dma.dma_write_ctrl_data_size != 3'b010) err_size_q <= 1'b1;
      end else if (rd_beat_hs) begin
        remaining_q <= remaining_q - 32'd1;
        if (remaining_q == 32'd1) begin
          rd_vld_q <= 1'b0;
        end else begin
          rd_dat_q <= mem[ptr_q];
          ptr_q    <= ptr_q + 1'b1;
        end
      end else if (wr_beat_hs) begin
        remaining_q <= remaining_q - 32'd1;
        ptr_q       <= ptr_q + 1'b1;
      end
    end
  end

  // Contents survive reset so a bench can inspect a partially written burst.
  always_ff @(posedge clk) begin
    if (wr_beat_hs)
      mem[ptr_q] <= dma.dma_write_chnl_data;
    else if (host_wr_ok)
      mem[host_addr] <= host_wdata;
  end

endmodule

// File: tb/tb_esp_dma32_mem_responder.sv
// Directed, table-driven bench for esp_dma32_mem_responder (ADDR_W = 10).
module tb_esp_dma32_mem_responder;
  logic        clk;
  logic        rst;
  logic        host_we;
  logic [9:0]  host_addr;
  logic [31:0] host_wdata;
  logic [31:0] host_rdata;
  logic        busy;
  logic        err_size;

  int n_chk;
  int n_fail;

  esp_dma32_mem_responder_if dma ();

  esp_dma32_mem_responder #(.ADDR_W(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .dma        (dma),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .busy       (busy),
    .err_size   (err_size)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] idx;
    logic [31:0] len;
    logic [2:0]  size;
    logic [31:0] first;
    logic        exp_err;
  } rd_vec_t;

  rd_vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic host_read(input logic [9:0] a, input logic [31:0] exp, input string name);
    @(posedge clk); #1;
    host_addr = a;
    @(posedge clk);
    @(negedge clk);
    chk(name, host_rdata, exp);
  endtask

  task automatic rd_burst(input logic [31:0] idx, input logic [31:0] len,
                          input logic [2:0] size, input logic [31:0] first);
    @(posedge clk); #1;
    dma.dma_read_ctrl_valid       = 1'b1;
    dma.dma_read_ctrl_data_index  = idx;
    dma.dma_read_ctrl_data_length = len;
    dma.dma_read_ctrl_data_size   = size;
    @(negedge clk);
    chk("rd_ctrl_rdy", {31'd0, dma.dma_read_ctrl_ready}, 32'd1);
    @(posedge clk); #1;
    dma.dma_read_ctrl_valid = 1'b0;
    dma.dma_read_chnl_ready = 1'b1;
    for (int k = 0; k < int'(len); k++) begin
      @(negedge clk);
      chk("rd_beat_vld", {31'd0, dma.dma_read_chnl_valid}, 32'd1);
      chk("rd_beat_dat", dma.dma_read_chnl_data, first + k);
      chk("rd_busy", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("rd_end_vld", {31'd0, dma.dma_read_chnl_valid}, 32'd0);
    chk("rd_end_busy", {31'd0, busy}, 32'd0);
    chk("rd_end_ctrl_rdy", {31'd0, dma.dma_read_ctrl_ready}, 32'd1);
    dma.dma_read_chnl_ready = 1'b0;
  endtask

  task automatic wr_burst(input logic [31:0] idx, input logic [31:0] len, input logic [31:0] d0);
    @(posedge clk); #1;
    dma.dma_write_ctrl_valid       = 1'b1;
    dma.dma_write_ctrl_data_index  = idx;
    dma.dma_write_ctrl_data_length = len;
    dma.dma_write_ctrl_data_size   = 3'b010;
    @(negedge clk);
    chk("wr_ctrl_rdy", {31'd0, dma.dma_write_ctrl_ready}, 32'd1);
    @(posedge clk); #1;
    dma.dma_write_ctrl_valid = 1'b0;
    dma.dma_write_chnl_valid = 1'b1;
    dma.dma_write_chnl_data  = d0;
    for (int k = 0; k < int'(len); k++) begin
      @(negedge clk);
      chk("wr_chnl_rdy", {31'd0, dma.dma_write_chnl_ready}, 32'd1);
      @(posedge clk); #1;
      dma.dma_write_chnl_data = d0 + k + 1;
    end
    dma.dma_write_chnl_valid = 1'b0;
    @(negedge clk);
    chk("wr_end_rdy", {31'd0, dma.dma_write_chnl_ready}, 32'd0);
    chk("wr_end_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    int cyc;
    n_chk  = 0;
    n_fail = 0;

    vecs[0] = '{idx: 32'd0, len: 32'd8, size: 3'b010, first: 32'h100, exp_err: 1'b0};
    vecs[1] = '{idx: 32'd5, len: 32'd3, size: 3'b010, first: 32'h105, exp_err: 1'b0};
    vecs[2] = '{idx: 32'd2, len: 32'd1, size: 3'b010, first: 32'h102, exp_err: 1'b0};
    vecs[3] = '{idx: 32'd6, len: 32'd1, size: 3'b011, first: 32'h106, exp_err: 1'b1};

    rst = 1'b1;
    host_we = 1'b0; host_addr = '0; host_wdata = '0;
    dma.dma_read_ctrl_valid = 1'b1;  dma.dma_read_ctrl_data_index = '0;
    dma.dma_read_ctrl_data_length = 32'd1; dma.dma_read_ctrl_data_size = 3'b010;
    dma.dma_read_chnl_ready = 1'b0;
    dma.dma_write_ctrl_valid = 1'b1; dma.dma_write_ctrl_data_index = '0;
    dma.dma_write_ctrl_data_length = 32'd1; dma.dma_write_ctrl_data_size = 3'b010;
    dma.dma_write_chnl_valid = 1'b1; dma.dma_write_chnl_data = '0;

    // Reset state, with requests offered to prove the readies are gated.
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst_rd_ctrl_rdy", {31'd0, dma.dma_read_ctrl_ready}, 32'd0);
    chk("rst_wr_ctrl_rdy", {31'd0, dma.dma_write_ctrl_ready}, 32'd0);
    chk("rst_rd_vld", {31'd0, dma.dma_read_chnl_valid}, 32'd0);
    chk("rst_wr_chnl_rdy", {31'd0, dma.dma_write_chnl_ready}, 32'd0);
    chk("rst_host_rdata", host_rdata, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err_size}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    dma.dma_read_ctrl_valid  = 1'b0;
    dma.dma_write_ctrl_valid = 1'b0;
    dma.dma_write_chnl_valid = 1'b0;

    // Preload mem[0..23] = 0x100 + i.
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      host_we = 1'b1; host_addr = 10'(i); host_wdata = 32'h100 + i;
    end
    @(posedge clk); #1;
    host_we = 1'b0;
    host_read(10'd3, 32'h103, "preload_rb");

    // Zero-length read: accepted, no beats, no busy.
    @(posedge clk); #1;
    dma.dma_read_ctrl_valid = 1'b1; dma.dma_read_ctrl_data_index = 32'd4;
    dma.dma_read_ctrl_data_length = 32'd0; dma.dma_read_ctrl_data_size = 3'b010;
    @(negedge clk);
    chk("len0_ctrl_rdy", {31'd0, dma.dma_read_ctrl_ready}, 32'd1);
    @(posedge clk); #1;
    dma.dma_read_ctrl_valid = 1'b0;
    dma.dma_read_chnl_ready = 1'b1;
    @(negedge clk);
    chk("len0_vld", {31'd0, dma.dma_read_chnl_valid}, 32'd0);
    chk("len0_busy", {31'd0, busy}, 32'd0);
    chk("len0_ctrl_rdy_after", {31'd0, dma.dma_read_ctrl_ready}, 32'd1);
    dma.dma_read_chnl_ready = 1'b0;

    for (int v = 0; v < 4; v++) begin
      rd_burst(vecs[v].idx, vecs[v].len, vecs[v].size, vecs[v].first);
      chk("vec_err_size", {31'd0, err_size}, {31'd0, vecs[v].exp_err});
    end

    // Stalled read: ready pattern 1,0,0,1,0,0,...
    @(posedge clk); #1;
    dma.dma_read_ctrl_valid = 1'b1; dma.dma_read_ctrl_data_index = 32'd2;
    dma.dma_read_ctrl_data_length = 32'd4; dma.dma_read_ctrl_data_size = 3'b010;
    @(posedge clk); #1;
    dma.dma_read_ctrl_valid = 1'b0;
    nb = 0; cyc = 0;
    while (nb < 4 && cyc < 40) begin
      dma.dma_read_chnl_ready = (cyc % 3 == 0);
      @(negedge clk);
      chk("stall_vld", {31'd0, dma.dma_read_chnl_valid}, 32'd1);
      chk("stall_dat", dma.dma_read_chnl_data, 32'h102 + nb);
      if (dma.dma_read_chnl_valid && dma.dma_read_chnl_ready) nb++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("stall_beats", nb, 32'd4);
    chk("stall_cycles", cyc, 32'd10);
    dma.dma_read_chnl_ready = 1'b1;
    @(negedge clk);
    chk("stall_no_extra", {31'd0, dma.dma_read_chnl_valid}, 32'd0);
    @(posedge clk); #1;
    dma.dma_read_chnl_ready = 1'b0;

    // Write wrapping past the top of memory.
    wr_burst(32'd1022, 32'd4, 32'hA0);
    host_read(10'd1022, 32'hA0, "wrap_1022");
    host_read(10'd1023, 32'hA1, "wrap_1023");
    host_read(10'd0, 32'hA2, "wrap_0");
    host_read(10'd1, 32'hA3, "wrap_1");

    // A write beat offered in IDLE is refused and lands nowhere.
    @(posedge clk); #1;
    dma.dma_write_chnl_valid = 1'b1; dma.dma_write_chnl_data = 32'hDEAD;
    @(negedge clk);
    chk("idle_wr_rdy", {31'd0, dma.dma_write_chnl_ready}, 32'd0);
    @(posedge clk); #1;
    dma.dma_write_chnl_valid = 1'b0;
    host_read(10'd2, 32'h102, "idle_wr_nomem");

    // Simultaneous read and write requests: read first, write after.
    @(posedge clk); #1;
    dma.dma_read_ctrl_valid = 1'b1; dma.dma_read_ctrl_data_index = 32'd4;
    dma.dma_read_ctrl_data_length = 32'd2; dma.dma_read_ctrl_data_size = 3'b010;
    dma.dma_write_ctrl_valid = 1'b1; dma.dma_write_ctrl_data_index = 32'd8;
    dma.dma_write_ctrl_data_length = 32'd1; dma.dma_write_ctrl_data_size = 3'b010;
    @(negedge clk);
    chk("both_rd_rdy", {31'd0, dma.dma_read_ctrl_ready}, 32'd1);
    chk("both_wr_rdy", {31'd0, dma.dma_write_ctrl_ready}, 32'd0);
    @(posedge clk); #1;
    dma.dma_read_ctrl_valid = 1'b0;
    dma.dma_read_chnl_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("both_rd_dat", dma.dma_read_chnl_data, 32'h104 + k);
      chk("both_wr_rdy_held", {31'd0, dma.dma_write_ctrl_ready}, 32'd0);
      @(posedge clk); #1;
    end
    dma.dma_read_chnl_ready = 1'b0;
    @(negedge clk);
    chk("both_wr_rdy_after", {31'd0, dma.dma_write_ctrl_ready}, 32'd1);
    @(posedge clk); #1;
    dma.dma_write_ctrl_valid = 1'b0;
    dma.dma_write_chnl_valid = 1'b1; dma.dma_write_chnl_data = 32'h55;
    @(negedge clk);
    chk("both_wr_chnl_rdy", {31'd0, dma.dma_write_chnl_ready}, 32'd1);
    @(posedge clk); #1;
    dma.dma_write_chnl_valid = 1'b0;
    host_read(10'd8, 32'h55, "both_wr_mem");

    // Reset after 3 of 8 write beats.
    @(negedge clk);
    chk("err_sticky", {31'd0, err_size}, 32'd1);
    @(posedge clk); #1;
    dma.dma_write_ctrl_valid = 1'b1; dma.dma_write_ctrl_data_index = 32'd16;
    dma.dma_write_ctrl_data_length = 32'd8; dma.dma_write_ctrl_data_size = 3'b010;
    @(posedge clk); #1;
    dma.dma_write_ctrl_valid = 1'b0;
    dma.dma_write_chnl_valid = 1'b1; dma.dma_write_chnl_data = 32'hB0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      dma.dma_write_chnl_data = 32'hB1 + k;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_wr_chnl_rdy", {31'd0, dma.dma_write_chnl_ready}, 32'd0);
    chk("mid_rst_rd_ctrl_rdy", {31'd0, dma.dma_read_ctrl_ready}, 32'd0);
    chk("mid_rst_wr_ctrl_rdy", {31'd0, dma.dma_write_ctrl_ready}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_err", {31'd0, err_size}, 32'd0);
    chk("mid_rst_host_rdata", host_rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    dma.dma_write_chnl_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_err", {31'd0, err_size}, 32'd0);
    host_read(10'd16, 32'hB0, "rst_mem16");
    host_read(10'd17, 32'hB1, "rst_mem17");
    host_read(10'd18, 32'hB2, "rst_mem18");
    host_read(10'd19, 32'h113, "rst_mem19");
    rd_burst(32'd16, 32'd3, 3'b010, 32'hB0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/esp_dma32_mem_responder.md
Name: esp_dma32_mem_responder

Overview:
- Memory-side responder for the 32-bit ESP DMA interface: accepts read/write control requests from an accelerator core, streams read data out on the read channel and absorbs write data from the write channel into an internal word array.
- Sits opposite the accelerator's DMA ports in block-level simulation and FPGA bring-up.
- A host backdoor port preloads and inspects memory while the DMA side is idle.

Parameters:
- ADDR_W, 10, word-address width; memory depth is 2**ADDR_W 32-bit words.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- dma_read_ctrl_valid  in  1  read request valid.
- dma_read_ctrl_data_index  in  32  start word index.
- dma_read_ctrl_data_length  in  32  beat count.
- dma_read_ctrl_data_size  in  3  beat size; only 3'b010 (32-bit) is legal.
- dma_read_ctrl_ready  out  1  read request accepted.
- dma_read_chnl_valid  out  1  read beat valid.
- dma_read_chnl_data  out  32  read beat data.
- dma_read_chnl_ready  in  1  core accepts read beat.
- dma_write_ctrl_valid  in  1  write request valid.
- dma_write_ctrl_data_index  in  32  start word index.
- dma_write_ctrl_data_length  in  32  beat count.
- dma_write_ctrl_data_size  in  3  beat size.
- dma_write_ctrl_ready  out  1  write request accepted.
- dma_write_chnl_valid  in  1  write beat valid.
- dma_write_chnl_data  in  32  write beat data.
- dma_write_chnl_ready  out  1  responder accepts write beat.
- host_we  in  1  backdoor write strobe.
- host_addr  in  ADDR_W  backdoor word address.
- host_wdata  in  32  backdoor write data.
- host_rdata  out  32  backdoor read data, registered, 1-cycle latency.
- busy  out  1  burst in progress.
- err_size  out  1  sticky illegal-size flag.

Behaviour:
- Clock and reset: clk is the single clock. rst is synchronous and active-high.
- Reset values: all outputs are 0 during reset, including both ctrl readies, both chnl valid/ready outputs, host_rdata, busy and err_size.
  - The FSM enters IDLE.
  - Memory contents are not cleared.
- FSM states: IDLE, RD, WR.
- IDLE:
  - dma_read_ctrl_ready and dma_write_ctrl_ready are 1 exactly when state is IDLE and rst is 0.
  - A handshake is valid&&ready.
  - If both requests are valid in the same cycle, read wins. Write ctrl ready is masked to 0 in that cycle, and the write request stays pending.
  - On handshake, latch base = index[ADDR_W-1:0] and remaining = length.
  - If size != 3'b010, set err_size and still execute the transfer as 32-bit.
  - length == 0: accept and stay in IDLE. No beats are produced or consumed, and busy stays 0.
  - length > 0: go to RD or WR; busy = 1 from the next cycle.
- RD:
  - dma_read_chnl_valid is registered. The first beat is valid in cycle T+1, where T is the ctrl handshake cycle. Data is mem[base].
  - Beat k carries mem[(base+k) mod 2**ADDR_W]; addresses wrap silently.
  - Valid and data are held stable while ready is 0.
  - On each beat handshake, remaining decrements. If beats remain, the next beat is presented in the following cycle, so throughput is back-to-back with ready held high.
  - After the last beat handshake, valid drops and the FSM returns to IDLE; ctrl readies are 1 in the next cycle.
- WR:
  - dma_write_chnl_ready = 1 while remaining > 0.
  - Each beat handshake writes data to mem[(base+k) mod 2**ADDR_W].
  - On the last beat handshake, ready drops in the next cycle and the FSM returns to IDLE.
  - Extra write beats offered in IDLE are not accepted (ready = 0).
- Length counter: remaining is a 32-bit counter with no truncation. Lengths above the memory depth wrap over memory.
- Host port:
  - host_rdata <= mem[host_addr] every cycle.
  - host_we is honoured only when busy == 0 and there is no write-beat handshake in the same cycle; otherwise it is dropped.
  - A read-after-host-write to the same address in the next cycle returns the new data.
- Reset mid-burst: the burst is abandoned and the FSM returns to IDLE. Beats already written remain in memory. The un-acked read beat is discarded.
- err_size: cleared only by rst.

Test Plan:
- Host-preload mem[0..7] = 0x100+i; read req index 0, length 8, size 3'b010, chnl_ready held 1 -> 8 beats 0x100..0x107 on consecutive cycles starting T+1; then busy = 0 and ctrl readies = 1.
- Read length 4 at index 2 with chnl_ready toggling 1,0,0,1,... -> data held stable during stalls; exactly 4 beats, 0x102..0x105, no duplicates or skips.
- Write req index 2**ADDR_W-2, length 4, data 0xA0..0xA3 -> host readback: mem[1022] = 0xA0, mem[1023] = 0xA1, mem[0] = 0xA2, mem[1] = 0xA3.
- Read and write ctrl valid in the same cycle -> read accepted first, write ctrl ready = 0; the write is accepted in the cycle after the read burst completes.
- Length-0 read, then a read with size 3'b011 and length 1 -> the first produces no beats and no busy; the second returns one beat and err_size = 1, sticky until rst.
- rst asserted after 3 of 8 write beats -> all outputs 0 during rst; 3 beats present in memory, the rest unchanged; the next request is accepted normally.
